// File: rtl/pipe_fetch_queue_if.sv
// Fetch-stage bus: instruction-memory port plus the valid/ready hand-off to ID.
// The fetch queue uses the master side; the surrounding pipeline uses the slave side.
interface pipe_fetch_queue_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 2
);
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_inst;
  logic             imem_valid;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             id_ready;
  logic             id_valid;
  logic [WIDTH-1:0] id_inst;
  logic [WIDTH-1:0] id_pc4;
  logic [AW:0]      count;

  modport master (
    output imem_addr, id_valid, id_inst, id_pc4, count,
    input  imem_inst, imem_valid, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_inst, id_pc4, count,
    output imem_inst, imem_valid, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/pipe_fetch_queue.sv
// IF stage: PC generator feeding a DEPTH-entry prefetch FIFO of {inst, pc+4}.
// A redirect flushes the FIFO and restarts fetch at the target PC.
module pipe_fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter int               AW       = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              resetn,
  pipe_fetch_queue_if.master bus
);

  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] PC_INC  = WIDTH'(4);

  typedef struct packed {
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] pc4;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop, push;

  always_comb begin
    pop      = (count_q != '0) & bus.id_ready;
    push     = bus.imem_valid & ~bus.redirect & ((count_q < DEPTH_C) | pop);
    mem_d    = mem_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{inst: bus.imem_inst, pc4: pc_q + PC_INC};
    end

    // Redirect overrides any pointer motion from a same-cycle pop.
    if (bus.redirect) begin
      pc_d     = bus.redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        pc_d     = pc_q + PC_INC;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.count     = count_q;
  assign bus.id_valid  = (count_q != '0);
  assign bus.id_inst   = bus.id_valid ? mem_q[rd_ptr_q].inst : '0;
  assign bus.id_pc4    = bus.id_valid ? mem_q[rd_ptr_q].pc4  : '0;

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Bench for pipe_fetch_queue: vector table with fixed expectations plus a
// scoreboard queue of pushed {inst, pc+4} entries checked as ID pops them.
module tb_pipe_fetch_queue;

  logic clock;
  logic resetn;

  pipe_fetch_queue_if #(.WIDTH(32), .AW(2)) bus ();

  pipe_fetch_queue #(.WIDTH(32), .DEPTH(4), .AW(2), .RESET_PC(32'h0)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Instruction memory: each word encodes its own address.
  assign bus.imem_inst = bus.imem_addr | 32'hA000_0000;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          pre_rst;
    bit          iv;
    bit          rdy;
    bit          rd;
    logic [31:0] rpc;
    logic [31:0] e_cnt;
    logic [31:0] e_addr;
    logic [31:0] e_vld;
    logic [31:0] e_pc4;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ent_t;

  vec_t        vec [$];
  ent_t        sb  [$];
  logic [31:0] m_pc;
  int          n_pass;
  int          n_tot;

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    else n_pass++;
  endtask

  task automatic add(input bit pr, input bit iv, input bit rdy, input bit rd, input logic [31:0] rpc,
                     input logic [31:0] c, input logic [31:0] a, input logic [31:0] v, input logic [31:0] p);
    vec.push_back('{pr, iv, rdy, rd, rpc, c, a, v, p});
  endtask

  task automatic reset_midstream(input int idx);
    #2 resetn = 1'b0;
    #1;
    chk("rst_addr",  idx, bus.imem_addr, 32'h0);
    chk("rst_count", idx, 32'(bus.count), 32'd0);
    chk("rst_valid", idx, 32'(bus.id_valid), 32'd0);
    chk("rst_inst",  idx, bus.id_inst, 32'h0);
    chk("rst_pc4",   idx, bus.id_pc4, 32'h0);
    sb.delete();
    m_pc = 32'h0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    ent_t e;
    bit   pop_m, push_m;
    v = vec[i];
    bus.imem_valid  = v.iv;
    bus.id_ready    = v.rdy;
    bus.redirect    = v.rd;
    bus.redirect_pc = v.rpc;
    #1;
    pop_m = (sb.size() != 0) && v.rdy;
    if (pop_m) begin
      e = sb.pop_front();
      chk("pop_valid", i, 32'(bus.id_valid), 32'd1);
      chk("pop_pc4",   i, bus.id_pc4, e.pc4);
      chk("pop_inst",  i, bus.id_inst, e.inst);
    end
    push_m = v.iv && !v.rd && (sb.size() < 4);
    @(posedge clock);
    if (v.rd) begin
      sb.delete();
      m_pc = v.rpc;
    end else if (push_m) begin
      sb.push_back('{m_pc | 32'hA000_0000, m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
    end
    @(negedge clock);
    chk("count",    i, 32'(bus.count), v.e_cnt);
    chk("addr",     i, bus.imem_addr, v.e_addr);
    chk("id_valid", i, 32'(bus.id_valid), v.e_vld);
    chk("id_pc4",   i, bus.id_pc4, v.e_pc4);
    chk("m_count",  i, 32'(bus.count), 32'(sb.size()));
    chk("m_addr",   i, bus.imem_addr, m_pc);
    chk("m_inst",   i, bus.id_inst, (sb.size() != 0) ? sb[0].inst : 32'h0);
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    m_pc   = 32'h0;
    resetn = 1'b0;
    bus.imem_valid  = 1'b0;
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Wait states from PC 0, then one entry left queued for the reset check.
    add(0,1,1,0,0, 1,32'h04,1,32'h04);
    add(0,0,1,0,0, 0,32'h04,0,32'h00);
    add(0,0,1,0,0, 0,32'h04,0,32'h00);
    add(0,1,1,0,0, 1,32'h08,1,32'h08);
    add(0,0,1,0,0, 0,32'h08,0,32'h00);
    add(0,1,0,0,0, 1,32'h0C,1,32'h0C);
    // Fill after reset, then hold while full.
    add(1,1,0,0,0, 1,32'h04,1,32'h04);
    add(0,1,0,0,0, 2,32'h08,1,32'h04);
    add(0,1,0,0,0, 3,32'h0C,1,32'h04);
    add(0,1,0,0,0, 4,32'h10,1,32'h04);
    add(0,1,0,0,0, 4,32'h10,1,32'h04);
    // Full with pop every cycle: pointers wrap.
    add(0,1,1,0,0, 4,32'h14,1,32'h08);
    add(0,1,1,0,0, 4,32'h18,1,32'h0C);
    add(0,1,1,0,0, 4,32'h1C,1,32'h10);
    add(0,1,1,0,0, 4,32'h20,1,32'h14);
    add(0,1,1,0,0, 4,32'h24,1,32'h18);
    add(0,1,1,0,0, 4,32'h28,1,32'h1C);
    // Drain with fetch stalled.
    add(0,0,1,0,0, 3,32'h28,1,32'h20);
    add(0,0,1,0,0, 2,32'h28,1,32'h24);
    add(0,0,1,0,0, 1,32'h28,1,32'h28);
    add(0,0,1,0,0, 0,32'h28,0,32'h00);
    // Redirect at count=3 with a same-cycle pop.
    add(0,1,0,0,0, 1,32'h2C,1,32'h2C);
    add(0,1,0,0,0, 2,32'h30,1,32'h2C);
    add(0,1,0,0,0, 3,32'h34,1,32'h2C);
    add(0,1,1,1,32'h400, 0,32'h400,0,32'h000);
    add(0,1,0,0,0, 1,32'h404,1,32'h404);
    add(0,1,0,0,0, 2,32'h408,1,32'h404);
    add(0,1,0,0,0, 3,32'h40C,1,32'h404);
    // Redirect vs push at DEPTH-1, then back-to-back redirects.
    add(0,1,0,1,32'h800, 0,32'h800,0,32'h000);
    add(0,1,0,1,32'h900, 0,32'h900,0,32'h000);
    add(0,1,1,1,32'hA00, 0,32'hA00,0,32'h000);
    add(0,1,0,0,0, 1,32'hA04,1,32'hA04);
    add(0,0,1,0,0, 0,32'hA04,0,32'h000);

    @(negedge clock);
    chk("reset_addr",  -1, bus.imem_addr, 32'h0);
    chk("reset_count", -1, 32'(bus.count), 32'd0);
    chk("reset_valid", -1, 32'(bus.id_valid), 32'd0);
    chk("reset_inst",  -1, bus.id_inst, 32'h0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < vec.size(); i++) begin
      if (vec[i].pre_rst) reset_midstream(i);
      run_vec(i);
    end

    chk("sb_empty", vec.size(), 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
